fft_stage_sequencer: RTL

//  Sequences an in-place radix-2 decimation-in-time FFT over an N-point sample RAM.

---
 rtl/fft_stage_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fft_stage_sequencer.sv
// Butterfly address/twiddle sequencer for an in-place radix-2 DIT FFT.
// Issues one descriptor per handshake and holds a barrier between stages.
module fft_stage_sequencer #(
    parameter int LOG2N = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             bf_valid,
    input  logic             bf_ready,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-2:0] tw_idx,
    output logic [3:0]       stage,
    input  logic             wb_done
);

    localparam int N = 1 << LOG2N;
    localparam int KW = LOG2N - 1;
    localparam int OUT_W = $clog2(N / 2 + 1);
    localparam logic [3:0] LAST_STAGE = 4'(LOG2N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [LOG2N-1:0] a;
        logic [LOG2N-1:0] b;
        logic [KW-1:0]    tw;
    } desc_t;

    // Butterfly k of stage s: groups of span 2h, offset pos inside the group.
    function automatic desc_t bf_desc(input logic [3:0] s,
                                      input logic [KW-1:0] kk);
        logic [LOG2N-1:0] h;
        logic [LOG2N-1:0] kx;
        logic [LOG2N-1:0] pos;
        logic [LOG2N-1:0] grp;
        logic [LOG2N-1:0] a;
        desc_t            d;
        h     = LOG2N'(1) << s;
        kx    = {1'b0, kk};
        pos   = kx & (h - LOG2N'(1));
        grp   = kx >> s;
        a     = (grp << (s + 4'd1)) | pos;
        d.a   = a;
        d.b   = a + h;
        d.tw  = pos[KW-1:0] << (LAST_STAGE - s);
        return d;
    endfunction

    state_t           state;
    logic [KW-1:0]    k;
    logic [3:0]       stage_q;
    logic [OUT_W-1:0] out_cnt;
    logic [OUT_W-1:0] out_next;
    logic             wb_underflow;
    desc_t            desc_q;
    logic             xfer;
    logic             k_last;

    assign xfer   = bf_valid && bf_ready;
    assign k_last = (k == '1);
    assign addr_a = desc_q.a;
    assign addr_b = desc_q.b;
    assign tw_idx = desc_q.tw;
    assign stage  = stage_q;

    // A transfer and a retire in the same cycle cancel out.
    always_comb begin
        out_next     = out_cnt;
        wb_underflow = 1'b0;
        if (xfer && !wb_done) begin
            out_next = out_cnt + OUT_W'(1);
        end else if (!xfer && wb_done) begin
            if (out_cnt == '0) begin
                wb_underflow = 1'b1;
            end else begin
                out_next = out_cnt - OUT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            k        <= '0;
            stage_q  <= '0;
            out_cnt  <= '0;
            desc_q   <= '0;
            bf_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else if (abort) begin
            state    <= S_IDLE;
            k        <= '0;
            stage_q  <= '0;
            out_cnt  <= '0;
            desc_q   <= '0;
            bf_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            if (wb_underflow) begin
                err <= 1'b1;
            end
        end else begin
            out_cnt <= out_next;
            done    <= 1'b0;
            if (wb_underflow) begin
                err <= 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_ISSUE;
                        k        <= '0;
                        stage_q  <= '0;
                        err      <= 1'b0;
                        bf_valid <= 1'b1;
                        busy     <= 1'b1;
                        desc_q   <= bf_desc(4'd0, '0);
                    end
                end
                S_ISSUE: begin
                    if (xfer) begin
                        if (k_last) begin
                            state    <= S_DRAIN;
                            bf_valid <= 1'b0;
                        end else begin
                            k      <= k + KW'(1);
                            desc_q <= bf_desc(stage_q, k + KW'(1));
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_next == '0) begin
                        if (stage_q != LAST_STAGE) begin
                            state    <= S_ISSUE;
                            stage_q  <= stage_q + 4'd1;
                            k        <= '0;
                            bf_valid <= 1'b1;
                            desc_q   <= bf_desc(stage_q + 4'd1, '0);
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
